pipeline_hazard_controller: RTL and testbench

//  Central stall/flush sequencer for the five-stage pipeline. Merges load-use hits, multi-cycle

---
 rtl/pipeline_hazard_controller.sv | 232 +++++++++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
// Central stall/flush sequencer for the five-stage pipeline. It merges load-use
// hazards, multi-cycle data-memory accesses, taken branches resolved in EX and
// external interrupts into one set of write enables, flushes and holds.
// A single FSM (RUN, MEM_WAIT, INT_DRAIN, INT_ACK) arbitrates by priority.
// Optional feature macro: STALL_STATS_EN adds saturating stall/flush counters.
module pipeline_hazard_controller #(
    parameter int MEM_LAT   = 1,
    parameter int DRAIN_CYC = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_use_hit_i,
    input  logic             mem_req_i,
    input  logic             mem_two_word_i,
    input  logic             branch_taken_i,
    input  logic             int_req_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             ex_mem_hold_o,
    output logic             int_ack_o,
    output logic [2:0]       ctl_state_o
`ifdef STALL_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o
`endif
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        INT_DRAIN = 2'd2,
        INT_ACK   = 2'd3
    } state_e;

    localparam logic [4:0] LAT_P1     = 5'(MEM_LAT + 1);
    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYC - 1);

    state_e     state_q, state_d;
    logic [4:0] wait_cnt_q, wait_cnt_d;
    logic [3:0] drain_cnt_q, drain_cnt_d;
    logic       mem_served_q, mem_served_d;
    logic       ret_int_q, ret_int_d;

    logic [4:0] lat_words;
    logic [4:0] hold_n;
    logic       new_mem;
    logic       mem_go;
    logic       flush_evt;

    // Total hold cycles for the access in MEM and whether a fresh hold must start
    always_comb begin
        lat_words = mem_two_word_i ? {LAT_P1[3:0], 1'b0} : LAT_P1;
        hold_n    = lat_words - 5'd1;
        new_mem   = mem_req_i & ~mem_served_q;
        mem_go    = new_mem & (hold_n != 5'd0);
    end

    // State and counter registers; reset abandons any wait or drain in progress
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= RUN;
            wait_cnt_q   <= 5'd0;
            drain_cnt_q  <= 4'd0;
            mem_served_q <= 1'b0;
            ret_int_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            mem_served_q <= mem_served_d;
            ret_int_q    <= ret_int_d;
        end
    end

    // Next-state logic: priority arbitration in RUN, countdowns in the wait states
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        mem_served_d = 1'b0;
        ret_int_d    = ret_int_q;
        case (state_q)
            RUN: begin
                if (mem_go) begin
                    ret_int_d = 1'b0;
                    if (hold_n == 5'd1) begin
                        mem_served_d = 1'b1;
                    end else begin
                        state_d    = MEM_WAIT;
                        wait_cnt_d = hold_n - 5'd1;
                    end
                end else if (branch_taken_i || load_use_hit_i) begin
                    state_d = RUN;
                end else if (int_req_i) begin
                    if (DRAIN_CYC <= 1) begin
                        state_d = INT_ACK;
                    end else begin
                        state_d     = INT_DRAIN;
                        drain_cnt_d = DRAIN_INIT;
                    end
                end
            end
            MEM_WAIT: begin
                wait_cnt_d = wait_cnt_q - 5'd1;
                if (wait_cnt_q <= 5'd1) begin
                    mem_served_d = 1'b1;
                    wait_cnt_d   = 5'd0;
                    state_d      = ret_int_q ? INT_DRAIN : RUN;
                    ret_int_d    = 1'b0;
                end
            end
            INT_DRAIN: begin
                if (mem_go) begin
                    ret_int_d = 1'b1;
                    if (hold_n == 5'd1) begin
                        mem_served_d = 1'b1;
                    end else begin
                        state_d    = MEM_WAIT;
                        wait_cnt_d = hold_n - 5'd1;
                    end
                end else begin
                    drain_cnt_d = drain_cnt_q - 4'd1;
                    if (drain_cnt_q <= 4'd1) begin
                        drain_cnt_d = 4'd0;
                        state_d     = INT_ACK;
                    end
                end
            end
            INT_ACK: begin
                ret_int_d = 1'b0;
                state_d   = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Pipeline control outputs decoded from current state and this cycle's hazards
    always_comb begin
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        ex_mem_hold_o  = 1'b0;
        int_ack_o      = 1'b0;
        flush_evt      = 1'b0;
        if (rst_i) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_go) begin
                        pc_write_o    = 1'b0;
                        if_id_write_o = 1'b0;
                        ex_mem_hold_o = 1'b1;
                    end else if (branch_taken_i) begin
                        if_id_flush_o  = 1'b1;
                        id_ex_bubble_o = 1'b1;
                        flush_evt      = 1'b1;
                    end else if (load_use_hit_i) begin
                        pc_write_o     = 1'b0;
                        if_id_write_o  = 1'b0;
                        id_ex_bubble_o = 1'b1;
                    end else if (int_req_i) begin
                        if_id_flush_o = 1'b1;
                        pc_write_o    = 1'b0;
                    end
                end
                MEM_WAIT: begin
                    pc_write_o    = 1'b0;
                    if_id_write_o = 1'b0;
                    ex_mem_hold_o = 1'b1;
                end
                INT_DRAIN: begin
                    if_id_flush_o = 1'b1;
                    pc_write_o    = 1'b0;
                    if (mem_go) begin
                        if_id_write_o = 1'b0;
                        ex_mem_hold_o = 1'b1;
                    end else if (branch_taken_i) begin
                        id_ex_bubble_o = 1'b1;
                        pc_write_o     = 1'b1;
                        flush_evt      = 1'b1;
                    end
                end
                INT_ACK: begin
                    int_ack_o     = 1'b1;
                    pc_write_o    = 1'b1;
                    if_id_flush_o = 1'b1;
                end
                default: begin
                    pc_write_o = 1'b1;
                end
            endcase
        end
    end

    assign ctl_state_o = {1'b0, state_q};

`ifdef STALL_STATS_EN
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] flush_count_q;

    // Saturating counters of PC-stall cycles and branch flushes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (!pc_write_o && (stall_cycles_q != {CNT_W{1'b1}})) begin
                stall_cycles_q <= stall_cycles_q + 1'b1;
            end
            if (flush_evt && (flush_count_q != {CNT_W{1'b1}})) begin
                flush_count_q <= flush_count_q + 1'b1;
            end
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller
// Directed-vector bench for pipeline_hazard_controller with MEM_LAT=1 and
// DRAIN_CYC=3. Inputs change on the falling edge, outputs are sampled 1 ns
// later, so each vector describes one clock cycle of the pipeline.
// With STALL_STATS_EN defined, the statistics counters are checked as well.
module tb_pipeline_hazard_controller;

    localparam int CNT_W = 3;

    logic       clk;
    logic       rst;
    logic       loadUseHit;
    logic       memReq;
    logic       memTwoWord;
    logic       branchTaken;
    logic       intReq;
    logic       pcWrite;
    logic       ifIdWrite;
    logic       ifIdFlush;
    logic       idExBubble;
    logic       exMemHold;
    logic       intAck;
    logic [2:0] ctlState;
`ifdef STALL_STATS_EN
    logic [CNT_W-1:0] stallCycles;
    logic [CNT_W-1:0] flushCount;
`endif

    int assertCount = 0;
    int failCount   = 0;

    // Packed view: {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold, int_ack, state}
    logic [8:0] outVec;
    assign outVec = {pcWrite, ifIdWrite, ifIdFlush, idExBubble, exMemHold, intAck, ctlState};

    localparam logic [8:0] V_RST_RUN  = 9'b001100_000;
    localparam logic [8:0] V_RST_MW   = 9'b001100_001;
    localparam logic [8:0] V_IDLE     = 9'b110000_000;
    localparam logic [8:0] V_MEMHOLD  = 9'b000010_000;
    localparam logic [8:0] V_MEMWAIT  = 9'b000010_001;
    localparam logic [8:0] V_BRANCH   = 9'b111100_000;
    localparam logic [8:0] V_LOADUSE  = 9'b000100_000;
    localparam logic [8:0] V_INTREQ   = 9'b011000_000;
    localparam logic [8:0] V_DRAIN    = 9'b011000_010;
    localparam logic [8:0] V_DRAINMEM = 9'b001010_010;
    localparam logic [8:0] V_DRAINBR  = 9'b111100_010;
    localparam logic [8:0] V_ACK      = 9'b111001_011;

    pipeline_hazard_controller #(
        .MEM_LAT   (1),
        .DRAIN_CYC (3),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .load_use_hit_i (loadUseHit),
        .mem_req_i      (memReq),
        .mem_two_word_i (memTwoWord),
        .branch_taken_i (branchTaken),
        .int_req_i      (intReq),
        .pc_write_o     (pcWrite),
        .if_id_write_o  (ifIdWrite),
        .if_id_flush_o  (ifIdFlush),
        .id_ex_bubble_o (idExBubble),
        .ex_mem_hold_o  (exMemHold),
        .int_ack_o      (intAck),
        .ctl_state_o    (ctlState)
`ifdef STALL_STATS_EN
        ,
        .stall_cycles_o (stallCycles),
        .flush_count_o  (flushCount)
`endif
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs on the falling edge and settles before sampling
    task automatic applyStimulus(input logic r, input logic lu, input logic mr, input logic tw,
                                 input logic br, input logic ir);
        @(negedge clk);
        rst         = r;
        loadUseHit  = lu;
        memReq      = mr;
        memTwoWord  = tw;
        branchTaken = br;
        intReq      = ir;
        #1;
    endtask

    // One cycle of stimulus followed by a check of the packed control outputs
    task automatic step(input logic r, input logic lu, input logic mr, input logic tw,
                        input logic br, input logic ir, input string tag, input logic [8:0] expVec);
        applyStimulus(r, lu, mr, tw, br, ir);
        checkOutput(tag, {7'd0, outVec}, {7'd0, expVec});
    endtask

    // Directed scenarios
    initial begin
        rst         = 1'b1;
        loadUseHit  = 1'b0;
        memReq      = 1'b0;
        memTwoWord  = 1'b0;
        branchTaken = 1'b0;
        intReq      = 1'b0;

        // Reset held two cycles, then first free-running cycle
        applyStimulus(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, "reset_hold", V_RST_RUN);
        step(0, 0, 0, 0, 0, 0, "post_reset_run", V_IDLE);

        // Two-word access, N=3; branch during MEM_WAIT is ignored
        step(0, 0, 1, 1, 0, 0, "mem2_t0", V_MEMHOLD);
        step(0, 0, 1, 1, 1, 0, "mem2_t1_branch_ignored", V_MEMWAIT);
        step(0, 0, 1, 1, 0, 0, "mem2_t2", V_MEMWAIT);
        step(0, 0, 1, 1, 0, 0, "mem2_t3_no_retrigger", V_IDLE);
        step(0, 0, 0, 0, 0, 0, "mem2_idle", V_IDLE);

        // Single-word access, N=1: one hold cycle, no retrigger
        step(0, 0, 1, 0, 0, 0, "mem1_t0", V_MEMHOLD);
        step(0, 0, 1, 0, 0, 0, "mem1_t1_served", V_IDLE);

        // Memory beats branch, then the branch is taken once the hold is served
        step(0, 0, 0, 0, 0, 0, "gap", V_IDLE);
        step(0, 0, 1, 0, 1, 0, "mem_over_branch", V_MEMHOLD);
        step(0, 0, 1, 0, 1, 0, "branch_after_mem", V_BRANCH);

        // Branch beats load-use, then the load-use stall lasts one cycle
        step(0, 1, 0, 0, 1, 0, "branch_over_loaduse", V_BRANCH);
        step(0, 1, 0, 0, 0, 0, "loaduse_stall", V_LOADUSE);
        step(0, 0, 0, 0, 0, 0, "loaduse_done", V_IDLE);

        // Interrupt with DRAIN_CYC=3: drain T0..T2, ack at T3, RUN at T4
        step(0, 0, 0, 0, 0, 1, "int_t0", V_INTREQ);
        step(0, 0, 0, 0, 0, 1, "int_t1", V_DRAIN);
        step(0, 1, 0, 0, 0, 1, "int_t2_loaduse_ignored", V_DRAIN);
        step(0, 0, 0, 0, 0, 1, "int_t3_ack", V_ACK);
        step(0, 0, 0, 0, 0, 0, "int_t4_run", V_IDLE);

        // Single-word access at drain T1 freezes the drain, ack moves to T4
        step(0, 0, 0, 0, 0, 1, "intmem_t0", V_INTREQ);
        step(0, 0, 1, 0, 0, 1, "intmem_t1_hold", V_DRAINMEM);
        step(0, 0, 0, 0, 0, 1, "intmem_t2", V_DRAIN);
        step(0, 0, 0, 0, 0, 1, "intmem_t3", V_DRAIN);
        step(0, 0, 0, 0, 0, 1, "intmem_t4_ack", V_ACK);
        step(0, 0, 0, 0, 0, 0, "intmem_t5_run", V_IDLE);

        // Branch during drain redirects the saved PC but does not extend the drain
        step(0, 0, 0, 0, 0, 1, "intbr_t0", V_INTREQ);
        step(0, 0, 0, 0, 1, 1, "intbr_t1_branch", V_DRAINBR);
        step(0, 0, 0, 0, 0, 1, "intbr_t2", V_DRAIN);
        step(0, 0, 0, 0, 0, 1, "intbr_t3_ack", V_ACK);
        step(0, 0, 0, 0, 0, 0, "intbr_t4_run", V_IDLE);

        // Reset in the second MEM_WAIT cycle abandons the access
        step(0, 0, 1, 1, 0, 0, "rstmw_t0", V_MEMHOLD);
        step(0, 0, 1, 1, 0, 0, "rstmw_t1", V_MEMWAIT);
        step(1, 0, 1, 1, 0, 0, "rstmw_t2_reset", V_RST_MW);
        step(0, 0, 0, 0, 0, 0, "rstmw_t3_run", V_IDLE);

        // Reset mid-drain leaves no pending acknowledge
        step(0, 0, 0, 0, 0, 1, "rstdr_t0", V_INTREQ);
        step(1, 0, 0, 0, 0, 0, "rstdr_t1_reset", 9'b001100_010);
        step(0, 0, 0, 0, 0, 0, "rstdr_t2_run", V_IDLE);
        step(0, 0, 0, 0, 0, 0, "rstdr_t3_no_ack", V_IDLE);

`ifdef STALL_STATS_EN
        // Three load-use stalls and two branch flushes after a fresh reset
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 0);
            applyStimulus(0, 0, 0, 0, 0, 0);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0);
            applyStimulus(0, 0, 0, 0, 0, 0);
        end
        checkOutput("stall_cycles_3", {13'd0, stallCycles}, 16'd3);
        checkOutput("flush_count_2", {13'd0, flushCount}, 16'd2);

        // Six more stalls would reach 9; a 3-bit counter must stop at 7
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("stall_cycles_sat", {13'd0, stallCycles}, 16'd7);
        checkOutput("flush_count_hold", {13'd0, flushCount}, 16'd2);

        // Six more branches saturate the flush counter at 7 as well
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("flush_count_sat", {13'd0, flushCount}, 16'd7);

        // Reset clears both counters
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("stats_cleared", {10'd0, stallCycles, flushCount}, 16'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
